ps2_keycode_rx: RTL and testbench

- PS/2 keyboard receiver on the 50 MHz domain; produces the keyCode/dataReady pair consumed by the VGA typewriter's key-to-ASCII path.
- Synchronises and deglitches PS/2 clock/data and deserialises 11-bit device-to-host frames.
- Strips E0 (extended) and F0 (break) prefixes and emits one strobe per make code; release events are suppressed.

---
 rtl/ps2_keycode_rx.sv | 178 +++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, deserialises 11-bit frames and
// turns make codes into a keyCode/dataReady strobe with E0/F0 prefix handling.
module ps2_keycode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned KEY_WIDTH      = 8
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [KEY_WIDTH-1:0] keyCode,
    output logic                 dataReady,
    output logic                 keyExt,
    output logic                 frameErr
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]     clk_sync_q, data_sync_q;
    logic           clk_s, data_s;
    logic           clk_filt_q, clk_filt_prev_q;
    logic [FCW-1:0] filt_cnt_q;
    logic           fall;

    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           parity_q, parity_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           brk_q, brk_d;
    logic           ext_pend_q, ext_pend_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic           key_ext_q, key_ext_d;
    logic           ready_q, ready_d;
    logic           err_q, err_d;
    logic           timeout;

    // Lines idle high, so the synchronisers and filter start at 1 to avoid a false edge.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q      <= 2'b11;
            data_sync_q     <= 2'b11;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
            filt_cnt_q      <= '0;
        end else begin
            clk_sync_q      <= {clk_sync_q[0], ps2_clk};
            data_sync_q     <= {data_sync_q[0], ps2_data};
            clk_filt_prev_q <= clk_filt_q;
            if (clk_s != clk_filt_q) begin
                if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                    clk_filt_q <= clk_s;
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + FCW'(1);
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_filt_prev_q & ~clk_filt_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            brk_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            key_q      <= '0;
            key_ext_q  <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            brk_q      <= brk_d;
            ext_pend_q <= ext_pend_d;
            key_q      <= key_d;
            key_ext_q  <= key_ext_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // A fall always wins over the timeout, so a frame edge on the last count is still taken.
    assign timeout = (state_q != StIdle) && !fall && (tmo_q == TCW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        parity_d   = parity_q;
        brk_d      = brk_q;
        ext_pend_d = ext_pend_q;
        key_d      = key_q;
        key_ext_d  = key_ext_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        tmo_d      = (state_q == StIdle || fall) ? '0 : tmo_q + TCW'(1);

        case (state_q)
            StIdle: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (data_s && (^{shift_q, parity_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (brk_q) begin
                            brk_d      = 1'b0;
                            ext_pend_d = 1'b0;
                        end else begin
                            key_d      = KEY_WIDTH'(shift_q);
                            key_ext_d  = ext_pend_q;
                            ready_d    = 1'b1;
                            ext_pend_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            state_d    = StIdle;
            err_d      = 1'b1;
            brk_d      = 1'b0;
            ext_pend_d = 1'b0;
            tmo_d      = '0;
        end
    end

    assign keyCode   = key_q;
    assign keyExt    = key_ext_q;
    assign dataReady = ready_q;
    assign frameErr  = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed frame table, multi-cycle corner sequences and random
// frames checked against an event-level scan-code model. Timeout is scaled down for run time.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;

    localparam int unsigned TMO  = 1000;
    localparam int unsigned LAT  = 11;  // ps2_clk drop to strobe: 2 sync + 8 filter + 1 register
    localparam int          HALF = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       dr, ext, fe;

    ps2_keycode_rx #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO),
        .KEY_WIDTH     (8)
    ) dut (
        .clk_50m  (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keyCode  (key),
        .dataReady(dr),
        .keyExt   (ext),
        .frameErr (fe)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dr_tot = 0, fe_tot = 0, both_tot = 0;
    int         dr_cyc = 0, fe_cyc = 0;
    int         last_fall = 0;
    int         n_checks = 0, n_err = 0;

    always @(negedge clk) begin
        if (dr) begin
            dr_tot++;
            dr_cyc = cyc;
        end
        if (fe) begin
            fe_tot++;
            fe_cyc = cyc;
        end
        if (dr && fe) both_tot++;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad);
        return {1'b1, (~(^b)) ^ bad, b, 1'b0};
    endfunction

    // Drive the first n bits of a frame; glitch_at names a bit whose high phase gets a
    // 4-cycle low pulse.
    task automatic send_bits(input logic [10:0] bits, input int n, input int half,
                             input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                repeat (15) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (4) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (half - 19) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            ps2_clk   = 1'b0;
            last_fall = cyc;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int half,
                              input int glitch_at);
        send_bits(frame_bits(b, bad), 11, half, glitch_at);
        repeat (60) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad;
        int         exp_dr;
        int         exp_fe;
        logic [7:0] exp_key;
        bit         exp_ext;
    } vec_t;

    vec_t tbl[11];

    int         dr0, fe0;
    logic [7:0] key_m, code;
    bit         ext_m, brk_m, extp_m, bad;
    int         exp_dr, exp_fe, half;

    initial begin
        tbl[0]  = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0};
        tbl[1]  = '{8'hF0, 1'b0, 0, 0, 8'h1C, 1'b0};
        tbl[2]  = '{8'h1C, 1'b0, 0, 0, 8'h1C, 1'b0};
        tbl[3]  = '{8'hE0, 1'b0, 0, 0, 8'h1C, 1'b0};
        tbl[4]  = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b1};
        tbl[5]  = '{8'hE0, 1'b0, 0, 0, 8'h75, 1'b1};
        tbl[6]  = '{8'hF0, 1'b0, 0, 0, 8'h75, 1'b1};
        tbl[7]  = '{8'h75, 1'b0, 0, 0, 8'h75, 1'b1};
        tbl[8]  = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0};
        tbl[9]  = '{8'h1C, 1'b1, 0, 1, 8'h1C, 1'b0};
        tbl[10] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0};

        repeat (5) @(negedge clk);
        chk("rst_key", int'(key), 0);
        chk("rst_dr", int'(dr), 0);
        chk("rst_ext", int'(ext), 0);
        chk("rst_fe", int'(fe), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            dr0 = dr_tot;
            fe0 = fe_tot;
            send_frame(tbl[i].code, tbl[i].bad, HALF, -1);
            chk($sformatf("vec%0d_dr", i), dr_tot - dr0, tbl[i].exp_dr);
            chk($sformatf("vec%0d_fe", i), fe_tot - fe0, tbl[i].exp_fe);
            chk($sformatf("vec%0d_key", i), int'(key), int'(tbl[i].exp_key));
            chk($sformatf("vec%0d_ext", i), int'(ext), int'(tbl[i].exp_ext));
            if (tbl[i].exp_dr == 1) chk($sformatf("vec%0d_lat", i), dr_cyc, last_fall + LAT);
        end

        // Start bit of 1 is rejected in idle.
        fe0 = fe_tot;
        send_bits(11'h7FF, 1, HALF, -1);
        repeat (60) @(negedge clk);
        chk("start_err_fe", fe_tot - fe0, 1);
        chk("start_err_lat", fe_cyc, last_fall + LAT);

        // Partial frame stalls; timeout must also drop the pending E0.
        send_frame(8'hE0, 1'b0, HALF, -1);
        dr0 = dr_tot;
        fe0 = fe_tot;
        send_bits(frame_bits(8'h29, 1'b0), 5, HALF, -1);
        repeat (TMO + 100) @(negedge clk);
        chk("tmo_fe", fe_tot - fe0, 1);
        chk("tmo_cyc", fe_cyc, last_fall + LAT + TMO);
        send_frame(8'h29, 1'b0, HALF, -1);
        chk("tmo_next_dr", dr_tot - dr0, 1);
        chk("tmo_next_key", int'(key), 8'h29);
        chk("tmo_next_ext", int'(ext), 0);
        chk("tmo_next_fe", fe_tot - fe0, 1);

        // Short low glitch inside a bit must not count as an edge.
        dr0 = dr_tot;
        fe0 = fe_tot;
        send_frame(8'h4B, 1'b0, HALF, 4);
        chk("glitch_dr", dr_tot - dr0, 1);
        chk("glitch_key", int'(key), 8'h4B);
        chk("glitch_fe", fe_tot - fe0, 0);

        // Reset mid-frame with an E0 pending.
        send_frame(8'hE0, 1'b0, HALF, -1);
        dr0 = dr_tot;
        send_bits(frame_bits(8'h1C, 1'b0), 3, HALF, -1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_key", int'(key), 0);
        chk("midrst_ext", int'(ext), 0);
        chk("midrst_dr", int'(dr), 0);
        chk("midrst_fe", int'(fe), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_strobe", dr_tot - dr0, 0);
        send_frame(8'h1C, 1'b0, HALF, -1);
        chk("midrst_next_dr", dr_tot - dr0, 1);
        chk("midrst_next_key", int'(key), 8'h1C);
        chk("midrst_next_ext", int'(ext), 0);

        // Random frames against the scan-code model; state is known: last event was a 1C make.
        key_m  = 8'h1C;
        ext_m  = 1'b0;
        brk_m  = 1'b0;
        extp_m = 1'b0;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    code = 8'hE0;
                2, 3:    code = 8'hF0;
                default: code = 8'($urandom_range(0, 255));
            endcase
            bad    = ($urandom_range(0, 7) == 0);
            half   = int'($urandom_range(20, 40));
            exp_dr = 0;
            exp_fe = 0;
            if (bad) begin
                exp_fe = 1;
            end else if (code == 8'hE0) begin
                extp_m = 1'b1;
            end else if (code == 8'hF0) begin
                brk_m = 1'b1;
            end else if (brk_m) begin
                brk_m  = 1'b0;
                extp_m = 1'b0;
            end else begin
                exp_dr = 1;
                key_m  = code;
                ext_m  = extp_m;
                extp_m = 1'b0;
            end
            dr0 = dr_tot;
            fe0 = fe_tot;
            send_frame(code, bad, half, -1);
            chk($sformatf("rnd%0d_dr", i), dr_tot - dr0, exp_dr);
            chk($sformatf("rnd%0d_fe", i), fe_tot - fe0, exp_fe);
            chk($sformatf("rnd%0d_key", i), int'(key), int'(key_m));
            chk($sformatf("rnd%0d_ext", i), int'(ext), int'(ext_m));
        end

        chk("dr_fe_overlap", both_tot, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
